// File: rtl/qam4_serial_modulator.sv
// ---------------------------------------------------------------------------
// qam4_serial_modulator
//
// 4-QAM (QPSK) modulator with a bit-serial output. Each 2-bit symbol
// modulates one full period of a 16-sample digital carrier. Each carrier
// sample is I*cos + Q*sin, an 8-bit two's complement word. Words leave the
// block LSB first, one bit per clock, with no gaps between samples or symbols.
//
// Ports:
//   clk                   - system clock; all state changes on the rising edge
//   rst                   - asynchronous, active-low reset
//   data_in[1:0]          - symbol; bit1 gives the I sign, bit0 the Q sign
//                           (0 = +1, 1 = -1). It is sampled once per symbol,
//                           at the load of carrier sample 0.
//   data_bit_out          - current serial sample bit (LSB first)
//   data_out_complete_bit - high while the MSB of the current sample is on
//                           data_bit_out
// ---------------------------------------------------------------------------
module qam4_serial_modulator #(
  parameter int SAMPLE_W        = 8,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int AMP             = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] data_in,
  output logic       data_bit_out,
  output logic       data_out_complete_bit
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam int IDX_W = $clog2(SAMPLES_PER_SYM);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SAMPLE_W - 1);
  // Sine is the cosine table delayed by a quarter period.
  localparam logic [IDX_W-1:0] SIN_OFFSET = IDX_W'(SAMPLES_PER_SYM * 3 / 4);

  logic [SAMPLE_W-1:0] sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IDX_W-1:0]    sample_idx;
  logic [1:0]          sym;
  logic [1:0]          sym_next;

  // Quarter-wave-free cosine table, round(63*cos(2*pi*n/16)), rescaled to AMP.
  function automatic int cos_lut(input logic [3:0] n);
    int base;
    case (n)
      4'd0:    base = 63;
      4'd1:    base = 58;
      4'd2:    base = 45;
      4'd3:    base = 24;
      4'd4:    base = 0;
      4'd5:    base = -24;
      4'd6:    base = -45;
      4'd7:    base = -58;
      4'd8:    base = -63;
      4'd9:    base = -58;
      4'd10:   base = -45;
      4'd11:   base = -24;
      4'd12:   base = 0;
      4'd13:   base = 24;
      4'd14:   base = 45;
      4'd15:   base = 58;
      default: base = 0;
    endcase
    return (base * AMP) / 63;
  endfunction

  // I*C[n] + Q*S[n]. The sum never exceeds +/-90, so truncating to the
  // sample width keeps the exact two's complement value.
  function automatic logic [SAMPLE_W-1:0] sample_word(input logic [1:0] s,
                                                      input logic [3:0] idx);
    int c_val;
    int s_val;
    int sum;
    c_val = cos_lut(idx);
    s_val = cos_lut(idx + SIN_OFFSET);
    sum   = (s[1] ? -c_val : c_val) + (s[0] ? -s_val : s_val);
    return sum[SAMPLE_W-1:0];
  endfunction

  // A new symbol is accepted only at the start of a carrier period; the
  // rest of the period keeps the latched one.
  always_comb begin
    sym_next = sym;
    if (sample_idx == '0) begin
      sym_next = data_in;
    end
  end

  // Shift out the current word. On its last bit, reload with the next
  // carrier sample. After reset the shift register is empty, so the first
  // frame out is all zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      sample_idx <= '0;
      sym        <= 2'b00;
    end else if (bit_cnt == BIT_LAST) begin
      sym        <= sym_next;
      sr         <= sample_word(sym_next, sample_idx);
      sample_idx <= sample_idx + IDX_W'(1);
      bit_cnt    <= '0;
    end else begin
      sr      <= sr >> 1;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign data_bit_out          = sr[0];
  assign data_out_complete_bit = (bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_qam4_serial_modulator.sv
// ---------------------------------------------------------------------------
// tb_qam4_serial_modulator
//
// Directed bench for qam4_serial_modulator. A reference model computes the
// expected serial stream from elapsed cycles since reset release and real
// cos/sin arithmetic. A compare process checks both outputs on every falling
// edge. Hand-computed sample words are checked at selected points of each
// symbol.
// ---------------------------------------------------------------------------
module tb_qam4_serial_modulator;

  logic       clk;
  logic       rst;
  logic [1:0] data_in;
  logic       data_bit_out;
  logic       data_out_complete_bit;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Reference model state
  int         t;
  logic [1:0] msym;

  qam4_serial_modulator dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_in               (data_in),
    .data_bit_out          (data_bit_out),
    .data_out_complete_bit (data_out_complete_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0d, time %0t)",
               name, actual, expected, t, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d);
    data_in = d;
  endtask

  function automatic int roundReal(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Carrier sample n of symbol s, straight from the I*cos + Q*sin definition.
  function automatic int modelSample(input logic [1:0] s, input int n);
    real th;
    int  c;
    int  sn;
    int  i_sign;
    int  q_sign;
    th     = 2.0 * 3.14159265358979 * n / 16.0;
    c      = roundReal(63.0 * $cos(th));
    sn     = roundReal(63.0 * $sin(th));
    i_sign = s[1] ? -1 : 1;
    q_sign = s[0] ? -1 : 1;
    return i_sign * c + q_sign * sn;
  endfunction

  // Count output cycles since reset release. The cycle that ends a
  // frame just before a carrier period begins latches the symbol.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t    = 0;
      msym = 2'b00;
    end else begin
      if ((t % 8 == 7) && ((t / 8) % 16 == 0)) msym = data_in;
      t = t + 1;
    end
  end

  // Check every cycle: frame 0 is the zero filler, and frame k >= 1 carries
  // sample (k-1) mod 16 of the latched symbol, LSB first.
  always @(negedge clk) begin
    logic [7:0] eb;
    int         k;
    if (check_en) begin
      k  = t / 8;
      eb = (k == 0) ? 8'h00 : 8'(modelSample(msym, (k - 1) % 16));
      checkOutput("stream_bit", int'(data_bit_out), int'(eb[t % 8]));
      checkOutput("stream_complete", int'(data_out_complete_bit), (t % 8 == 7) ? 1 : 0);
    end
  end

  task automatic captureFrame(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b[i] = data_bit_out;
    end
  endtask

  // Capture one symbol. Check the listed sample indices against literals,
  // and optionally change data_in before sample chg_at.
  task automatic runSymbol(input string tag, input int idx_a, input logic [7:0] exp_a,
                           input int idx_b, input logic [7:0] exp_b,
                           input int idx_c, input logic [7:0] exp_c,
                           input int idx_d, input logic [7:0] exp_d,
                           input int chg_at, input logic [1:0] chg_val);
    logic [7:0] w;
    for (int s = 0; s < 16; s++) begin
      if (s == chg_at) applyStimulus(chg_val);
      captureFrame(w);
      if (s == idx_a) checkOutput({tag, "_a"}, int'(w), int'(exp_a));
      if (s == idx_b) checkOutput({tag, "_b"}, int'(w), int'(exp_b));
      if (s == idx_c) checkOutput({tag, "_c"}, int'(w), int'(exp_c));
      if (s == idx_d) checkOutput({tag, "_d"}, int'(w), int'(exp_d));
    end
  endtask

  initial begin
    logic [7:0] w;
    rst     = 1'b1;
    data_in = 2'b00;
    #2 rst = 1'b0;
    #1 check_en = 1;
    $display("[TB] Starting qam4_serial_modulator test");

    // Pin the model against hand-computed values
    checkOutput("model_00_n2", modelSample(2'b00, 2), 90);
    checkOutput("model_11_n2", modelSample(2'b11, 2), -90);
    checkOutput("model_01_n6", modelSample(2'b01, 6), -90);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_bit", int'(data_bit_out), 0);
    checkOutput("reset_complete", int'(data_out_complete_bit), 0);

    @(posedge clk);
    #1 rst = 1'b1;
    captureFrame(w);
    checkOutput("filler_frame", int'(w), 8'h00);

    // Symbol 00. data_in flips to 11 at sample 5 and must be ignored.
    runSymbol("sym00", 0, 8'h3F, 2, 8'h5A, 4, 8'h3F, 8, 8'hC1, 5, 2'b11);
    // Symbol 11
    runSymbol("sym11", 0, 8'hC1, 2, 8'hA6, 4, 8'hC1, 10, 8'h5A, 1, 2'b01);
    // Symbol 01
    runSymbol("sym01", 0, 8'h3F, 2, 8'h00, 4, 8'hC1, 6, 8'hA6, 1, 2'b10);
    // Symbol 10. Sample 9 is -(-58) - 24 = 0x22.
    runSymbol("sym10", 0, 8'hC1, 2, 8'h00, 4, 8'h3F, 9, 8'h22, 1, 2'b00);

    // Symbol 00 again. Assert reset during bit 3 of sample 9 (0xAE).
    for (int s = 0; s < 9; s++) captureFrame(w);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_bit3", int'(data_bit_out), 1);
    rst = 1'b0;
    #1;
    checkOutput("async_reset_bit", int'(data_bit_out), 0);
    checkOutput("async_reset_complete", int'(data_out_complete_bit), 0);
    applyStimulus(2'b01);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    captureFrame(w);
    checkOutput("post_reset_filler", int'(w), 8'h00);
    captureFrame(w);
    checkOutput("post_reset_s0", int'(w), 8'h3F);
    captureFrame(w);
    captureFrame(w);
    checkOutput("post_reset_s2", int'(w), 8'h00);
    for (int s = 3; s < 8; s++) captureFrame(w);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam4_serial_modulator.md
Name: qam4_serial_modulator

Overview:
- 4-QAM (QPSK) baseband-to-carrier modulator with a serial output.
- Each 2-bit symbol drives one full period of a 16-sample digital carrier. Each sample is an I·cos + Q·sin sum, 8-bit two's complement.
- Samples are serialized LSB-first, one bit per clock, with a marker on each sample's last bit.
- Sits at the top of the transmit path; a downstream deserializer or DAC interface reassembles the 8-bit words.

Parameters:
- SAMPLE_W, 8, width of each output sample in bits (fixed at 8; the LUT is sized for it).
- SAMPLES_PER_SYM, 16, carrier samples per symbol (one full carrier period).
- AMP, 63, peak amplitude of the cos/sin LUT entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  2  symbol; bit1 selects I sign, bit0 selects Q sign.
- data_bit_out  output  1  serial sample bit, LSB first.
- data_out_complete_bit  output  1  high during the cycle in which bit 7 (MSB) of the current sample is on data_bit_out.

Behaviour:
- State registers:
  - sr[7:0]: shift register.
  - bit_cnt[2:0].
  - sample_idx[3:0].
  - sym[1:0]: latched symbol.
- Outputs:
  - data_bit_out = sr[0].
  - data_out_complete_bit = (bit_cnt == 7).
  - Both are decoded directly from registers, with no extra latency.
- Reset (rst=0, asynchronous): sr=0, bit_cnt=0, sample_idx=0, sym=00. Therefore data_bit_out=0 and data_out_complete_bit=0.
- Each rising edge with rst=1:
  - If bit_cnt != 7: sr ← sr >> 1 (zero fill); bit_cnt ← bit_cnt+1.
  - If bit_cnt == 7 (load):
    - sym_next = (sample_idx==0) ? data_in : sym.
    - sym ← sym_next.
    - sr ← sample(sym_next, sample_idx).
    - sample_idx ← sample_idx+1 (wraps 15→0).
    - bit_cnt ← 0.
- First 8 output cycles after reset release form an all-zero filler frame; complete still pulses on its 8th cycle. The first real sample is loaded on the 8th rising edge after reset release.
- Symbol mapping:
  - I = +1 if data_in[1]=0, −1 if 1.
  - Q = +1 if data_in[0]=0, −1 if 1.
- data_in is sampled only at the load edge where sample_idx==0, i.e. once per 128 clocks. Changes at any other time are ignored until the next symbol boundary.
- Carrier LUT:
  - C[n] = round(63·cos(2πn/16)), n=0..15: 63,58,45,24,0,−24,−45,−58,−63,−58,−45,−24,0,24,45,58.
  - S[n] = C[(n−4) mod 16], i.e. sine.
- Sample arithmetic:
  - sample = I·C[n] + Q·S[n], computed signed.
  - Result range is ±90, so it always fits 8-bit two's complement with no saturation needed.
  - Emitted as 8 raw bits.
- Frame timing:
  - Sample period is 8 clocks; symbol period is 128 clocks.
  - Output is continuous, with no gaps between samples or symbols.
- Reset asserted mid-sample or mid-symbol:
  - All state clears immediately.
  - After release the sequence restarts with the zero filler frame, then sample index 0 using the data_in present at that load edge.

Test Plan:
- Reset, data_in=00, release → 8 zero bits with complete on the 8th; next 8 bits LSB-first = 0x3F (+63). Sample 2 = 0x5A (+90); sample 4 = 0x3F; sample 8 = 0xC1 (−63).
- data_in=11 at symbol boundary → sample 0 = 0xC1, sample 2 = 0xA6 (−90), sample 4 = 0xC1, sample 10 = 0x5A.
- data_in=01 → sample 0 = 0x3F, sample 2 = 0x00, sample 4 = 0xC1, sample 6 = 0xA6.
- data_in=10 → sample 0 = 0xC1, sample 2 = 0x00, sample 4 = 0x3F.
- data_in changed from 00 to 11 mid-symbol (sample 5) → samples 5..15 still follow 00. The new symbol takes effect exactly at the next sample 0, 128 clocks after the previous boundary.
- Assert rst during bit 3 of sample 9 → data_bit_out=0 and complete=0 immediately (asynchronous). After release: a zero frame, then sample 0 of the current data_in. complete pulses every 8th cycle throughout.
